// File: rtl/lab5_tap_feeder.sv
// lab5_tap_feeder
// ---------------------------------------------------------------------------
// Upstream feed stage for the 3-tap lab5 multiply/sum datapath. It accepts
// paced 10-bit signed samples over a valid/ready handshake and keeps them in
// a 3-deep delay line. The line drives the datapath taps x1/x2/x3, and x_valid
// strobes each new tap set. y_valid is x_valid delayed by the datapath's
// 2-register latency, so it marks the cycles in which y is fresh.
//
// Parameters
//   DIV        minimum cycles between accepted samples (legal 1..255)
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear of taps, fill state, pacing, valid pipe, count
//   s_valid    upstream sample present
//   s_data     signed 10-bit sample
//   s_ready    sample can be accepted this cycle
//   x1/x2/x3   newest / previous / oldest sample (signed)
//   x_valid    one-cycle strobe: taps hold a new set
//   y_valid    x_valid delayed by exactly 2 cycles
//   sample_cnt accepted-sample count, wraps at 16 bits
//
// Build option
//   LAB5_FEED_ZEROFILL_EN  when defined, x_valid pulses on every accept and the
//                          unfilled taps read 0 (zero-padded start-up). When
//                          undefined, x_valid is held off until the line is full.
// ---------------------------------------------------------------------------
// state | meaning
// EMPTY | no samples in the delay line
// ONE   | x1 valid
// TWO   | x1, x2 valid
// FULL  | x1, x2, x3 valid
module lab5_tap_feeder #(
  parameter int unsigned DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              s_valid,
  input  logic signed [9:0] s_data,
  output logic              s_ready,
  output logic signed [9:0] x1,
  output logic signed [9:0] x2,
  output logic signed [9:0] x3,
  output logic              x_valid,
  output logic              y_valid,
  output logic [15:0]       sample_cnt
);

  localparam logic [7:0] PACE_LOAD = 8'(DIV - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    FULL  = 2'd3
  } fill_e;

  fill_e             fill_q, fill_d;
  logic [7:0]        pace_q;
  logic signed [9:0] x1_q, x2_q, x3_q;
  logic              x_valid_q;
  logic              y_pipe1_q, y_pipe2_q;
  logic [15:0]       cnt_q;
  logic              accept;
  logic              strobe_d;

  // clr masks ready so a colliding sample is never taken
  assign s_ready = (pace_q == 8'd0) && !clr;
  assign accept  = s_valid && s_ready;

  always_comb begin
    fill_d = fill_q;
    case (fill_q)
      EMPTY:   fill_d = ONE;
      ONE:     fill_d = TWO;
      TWO:     fill_d = FULL;
      default: fill_d = FULL;
    endcase
  end

`ifdef LAB5_FEED_ZEROFILL_EN
  // taps start from zero after reset/clear, so every accept yields a usable set
  assign strobe_d = 1'b1;
`else
  assign strobe_d = (fill_d == FULL);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q    <= EMPTY;
      pace_q    <= 8'd0;
      x1_q      <= '0;
      x2_q      <= '0;
      x3_q      <= '0;
      x_valid_q <= 1'b0;
      y_pipe1_q <= 1'b0;
      y_pipe2_q <= 1'b0;
      cnt_q     <= 16'd0;
    end else if (clr) begin
      fill_q    <= EMPTY;
      pace_q    <= 8'd0;
      x1_q      <= '0;
      x2_q      <= '0;
      x3_q      <= '0;
      x_valid_q <= 1'b0;
      y_pipe1_q <= 1'b0;
      y_pipe2_q <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      y_pipe1_q <= x_valid_q;
      y_pipe2_q <= y_pipe1_q;
      if (accept) begin
        fill_q    <= fill_d;
        pace_q    <= PACE_LOAD;
        x3_q      <= x2_q;
        x2_q      <= x1_q;
        x1_q      <= s_data;
        x_valid_q <= strobe_d;
        cnt_q     <= cnt_q + 16'd1;
      end else begin
        x_valid_q <= 1'b0;
        if (pace_q != 8'd0) begin
          pace_q <= pace_q - 8'd1;
        end
      end
    end
  end

  assign x1         = x1_q;
  assign x2         = x2_q;
  assign x3         = x3_q;
  assign x_valid    = x_valid_q;
  assign y_valid    = y_pipe2_q;
  assign sample_cnt = cnt_q;

endmodule

// File: doc/lab5_tap_feeder.md
# lab5_tap_feeder

Upstream feed stage for the 3-tap lab5 multiply/sum datapath. It accepts a paced stream of 10-bit signed samples over a valid/ready handshake and maintains a 3-deep delay line. It presents the delay line as the datapath's `x1`/`x2`/`x3` inputs, with a strobe marking each new tap set. It also generates `y_valid`, which is that strobe re-timed to the datapath's 2-register latency, so downstream logic knows when `y` is fresh.

## Interface

Parameters:
- `DIV`, default 4: minimum clock cycles between accepted samples. Legal range 1–255. With `DIV`=1, one sample per cycle.

Ports (name, direction, width, meaning):
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `clr`, in, 1: synchronous clear of delay line, fill state, pacing counter, valid pipe and sample counter.
- `s_valid`, in, 1: upstream sample present.
- `s_data`, in, 10: signed sample.
- `s_ready`, out, 1: block can accept `s_data` this cycle.
- `x1`, out, 10: newest sample, signed.
- `x2`, out, 10: previous sample, signed.
- `x3`, out, 10: oldest sample, signed.
- `x_valid`, out, 1: one-cycle strobe; `x1..x3` hold a new tap set.
- `y_valid`, out, 1: `x_valid` delayed exactly 2 cycles; aligns with datapath output `y`.
- `sample_cnt`, out, 16: count of accepted samples, unsigned.

## Operation

- **Accept:** an accept occurs when `s_valid && s_ready` is sampled at a rising edge.
- **s_ready:** `s_ready = (pace_cnt == 0) && !clr`, decoded combinationally from registered `pace_cnt`.
- **Pacing:** on accept, `pace_cnt` loads `DIV-1`. Otherwise it decrements while non-zero. With `DIV`=1, `s_ready` stays high.
- **Shift on accept:** `x3 <= x2`, `x2 <= x1`, `x1 <= s_data`. Values are passed through unmodified; no width change.
- **Fill FSM (2-bit):**
  - States: EMPTY → ONE → TWO → FULL, advancing one state per accept.
  - FULL stays FULL on accept.
  - No other transitions except clear/reset → EMPTY.
- **x_valid:** registered. It is high in the cycle after an accept whose resulting state is FULL (see Configuration for the zero-fill variant). Otherwise low.
- **sample_cnt:** increments by 1 per accept and wraps 0xFFFF → 0x0000.
- **clr:** has priority over a simultaneous accept; the sample is not taken because `s_ready` is low. Next cycle:
  - taps, `pace_cnt` and `sample_cnt` = 0;
  - state = EMPTY;
  - `x_valid` = 0 and both `y_valid` pipe stages = 0.
- **s_valid without s_ready:** no effect. Upstream must hold `s_data` until accepted.
- **Reset:** asserting `rst_n` low mid-stream immediately forces the same values as `clr`, asynchronously. After release, `s_ready` = 1.

## Timing

- Reset values: `x1`=`x2`=`x3`=0, `x_valid`=0, `y_valid`=0, `sample_cnt`=0, `s_ready`=1 (when `clr`=0).
- Accept at edge N:
  - new `x1..x3` and `x_valid` are visible after edge N;
  - the datapath registers the taps at edge N+1;
  - `y` updates at edge N+2, and `y_valid` is high after edge N+2 for one cycle.
- Next possible accept is edge N+`DIV`.
- Back-to-back accepts (`DIV`=1) produce back-to-back `x_valid`/`y_valid` pulses with no bubbles.
- `y_valid` pipe stages are cleared by `clr`. A pulse already in flight when `clr` is asserted is dropped.

## Configuration

- **`LAB5_FEED_ZEROFILL_EN` defined:**
  - `x_valid` pulses on every accept, including in EMPTY/ONE/TWO.
  - Taps not yet filled read 0, so the first outputs are the zero-padded filter start-up.
- **Not defined (default):**
  - `x_valid` is suppressed until the delay line is full.
  - The first strobe follows the 3rd accept after reset/clear.
- The fill FSM and `sample_cnt` behave identically in both builds.

## Test plan

- **Fill without macro:** `DIV`=4; feed 10, 20, 30 with `s_valid` held high. Expect:
  - accepts at cycles 0, 4, 8;
  - `x_valid` only after the 3rd accept, with `x1`=30, `x2`=20, `x3`=10;
  - `y_valid` 2 cycles later;
  - `sample_cnt`=3.
- **Zero-fill build:** same stimulus with `LAB5_FEED_ZEROFILL_EN` defined. Expect three `x_valid` pulses with taps (10,0,0), (20,10,0), (30,20,10).
- **Pacing:** `DIV`=3 with `s_valid` held high for 12 cycles. Expect:
  - `s_ready` pattern 1,0,0 repeating;
  - exactly 4 accepts;
  - `-512` and `+511` shift through unchanged.
- **Clear collision:** assert `clr` in the same cycle as `s_valid` with `s_ready` high, line FULL. Expect:
  - the sample is not accepted;
  - next cycle taps = 0, state EMPTY, `sample_cnt`=0;
  - a pending `y_valid` is not emitted.
- **Async reset mid-stream:** drop `rst_n` between clock edges while `pace_cnt`=2. Expect all outputs 0 immediately and `s_ready`=1 on release.
- **Counter wrap:** preload via 65535 accepts (`DIV`=1). Expect `sample_cnt`=0xFFFF, then 0x0000 after the next accept; `x_valid` unaffected.
